// File: rtl/hd_page_loader_if.sv
// Start request, HD read port and page write port of the program loader.
interface hd_page_loader_if #(
  parameter int DATA_W  = 32,
  parameter int HD_AW   = 10,
  parameter int PAGE_AW = 6,
  parameter int PID_W   = 5
);
  logic               Start;
  logic [PID_W-1:0]   StartPID;
  logic [HD_AW-1:0]   HDBase;
  logic [HD_AW-1:0]   HD_addr;
  logic [DATA_W-1:0]  HD_data;
  logic               Page_we;
  logic [PID_W-1:0]   Page_pid;
  logic [PAGE_AW-1:0] Page_addr;
  logic [DATA_W-1:0]  Page_data;
  logic               Busy;
  logic               Done;
  logic [PAGE_AW:0]   WordsLoaded;
  logic               Overflow;

  modport master (
    input  Start, StartPID, HDBase, HD_data,
    output HD_addr, Page_we, Page_pid, Page_addr, Page_data,
    output Busy, Done, WordsLoaded, Overflow
  );

  modport slave (
    output Start, StartPID, HDBase, HD_data,
    input  HD_addr, Page_we, Page_pid, Page_addr, Page_data,
    input  Busy, Done, WordsLoaded, Overflow
  );
endinterface

// File: rtl/hd_page_loader.sv
// Copies one program image from HD into a process page, stopping at the halt
// opcode or when the page is full; Busy selects BIOS instructions meanwhile.
module hd_page_loader #(
  parameter int         DATA_W  = 32,
  parameter int         HD_AW   = 10,
  parameter int         PAGE_AW = 6,
  parameter int         PID_W   = 5,
  parameter int         RD_LAT  = 1,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input logic              Clock,
  input logic              Reset,
  hd_page_loader_if.master bus
);
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  state_t             state;
  state_t             state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [PAGE_AW-1:0] idx;
  logic [PID_W-1:0]   pid;
  logic [HD_AW-1:0]   base;
  logic [HD_AW-1:0]   hd_addr;
  logic               accept;
  logic               vld_p0;
  logic               halt_p0;
  logic               last_p0;
  logic               vld_p1;
  logic [PAGE_AW-1:0] addr_p1;
  logic [PID_W-1:0]   pid_p1;
  logic [DATA_W-1:0]  data_p1;
  logic [PAGE_AW:0]   words;
  logic               overflow;

  function automatic logic is_halt(input logic [DATA_W-1:0] word);
    return word[DATA_W-1 -: 6] == HALT_OP;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    vld_p0   = 1'b0;
    last_p0  = 1'b0;
    halt_p0  = is_halt(bus.HD_data);
    case (state)
      IDLE: begin
        if (bus.Start) begin
          accept   = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (cnt == CNT_W'(RD_LAT - 1)) begin
          vld_p0   = 1'b1;
          last_p0  = halt_p0 || (&idx);
          state_nx = last_p0 ? FINISH : ISSUE;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // p0 -> p1: the sampled HD word becomes the page write in the next cycle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt      <= '0;
      idx      <= '0;
      pid      <= '0;
      base     <= '0;
      hd_addr  <= '0;
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      pid_p1   <= '0;
      data_p1  <= '0;
      words    <= '0;
      overflow <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (accept) begin
        pid      <= bus.StartPID;
        base     <= bus.HDBase;
        idx      <= '0;
        hd_addr  <= bus.HDBase;
        words    <= '0;
        overflow <= 1'b0;
      end
      if (state == ISSUE)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CNT_W'(1);
      if (vld_p0) begin
        addr_p1 <= idx;
        pid_p1  <= pid;
        data_p1 <= bus.HD_data;
        if (last_p0) begin
          words    <= (PAGE_AW + 1)'(idx) + (PAGE_AW + 1)'(1);
          // A final word that is not a halt can only mean the page filled up
          overflow <= !halt_p0;
        end else begin
          idx     <= idx + PAGE_AW'(1);
          hd_addr <= base + HD_AW'(idx) + HD_AW'(1);
        end
      end
    end
  end

  assign bus.HD_addr     = hd_addr;
  assign bus.Page_we     = vld_p1;
  assign bus.Page_addr   = addr_p1;
  assign bus.Page_pid    = pid_p1;
  assign bus.Page_data   = data_p1;
  assign bus.Busy        = (state != IDLE);
  assign bus.Done        = (state == FINISH);
  assign bus.WordsLoaded = words;
  assign bus.Overflow    = overflow;
endmodule

// File: tb/tb_hd_page_loader.sv
// Bench for hd_page_loader: three instances (default, 4-slot page, 3-cycle HD
// latency) checked every cycle against a load-level model plus literal points.
module tb_hd_page_loader;
  localparam int N        = 3;
  localparam int HD_DEPTH = 1024;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mem [N][HD_DEPTH];
  logic        st [N];
  logic [4:0]  spid [N];
  logic [9:0]  sbase [N];
  logic        rst_a [N];

  logic        o_busy [N], o_done [N], o_we [N], o_ovf [N];
  logic [31:0] o_addr [N], o_pid [N], o_data [N], o_hd [N], o_words [N];

  bit          mvalid [N], ld_on [N], ld_ovf [N], e_busy [N];
  int          ld_t [N], ld_base [N], ld_pid [N], ld_n [N];
  int          h_addr [N], h_pid [N];
  logic [31:0] h_data [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int PAW = (g == 1) ? 2 : 6;
    logic [31:0] pipe [4];

    hd_page_loader_if #(.DATA_W(32), .HD_AW(10), .PAGE_AW(PAW), .PID_W(5)) bus ();

    hd_page_loader #(
      .DATA_W(32), .HD_AW(10), .PAGE_AW(PAW), .PID_W(5),
      .RD_LAT(LAT), .HALT_OP(6'b111111)
    ) dut (
      .Clock(clk),
      .Reset(rst_a[g]),
      .bus(bus)
    );

    always @(posedge clk) begin
      pipe[0] <= mem[g][bus.HD_addr];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end

    assign bus.Start    = st[g];
    assign bus.StartPID = spid[g];
    assign bus.HDBase   = sbase[g];
    assign bus.HD_data  = pipe[LAT-1];
    assign o_busy[g]    = bus.Busy;
    assign o_done[g]    = bus.Done;
    assign o_we[g]      = bus.Page_we;
    assign o_ovf[g]     = bus.Overflow;
    assign o_addr[g]    = 32'(bus.Page_addr);
    assign o_pid[g]     = 32'(bus.Page_pid);
    assign o_data[g]    = bus.Page_data;
    assign o_hd[g]      = 32'(bus.HD_addr);
    assign o_words[g]   = 32'(bus.WordsLoaded);
  end

  function automatic int lat_of(input int g);
    return (g == 2) ? 3 : 1;
  endfunction

  function automatic int paw_of(input int g);
    return (g == 1) ? 2 : 6;
  endfunction

  task automatic cmp(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, g, cyc, act, exp);
    end
  endtask

  // Program length: words up to and including the first halt, else a full page.
  task automatic prog_len(input int g, input int base, output int n, output bit ovf);
    int depth;
    logic [31:0] w;
    depth = 1 << paw_of(g);
    n = depth;
    ovf = 1'b1;
    for (int i = 0; i < depth; i++) begin
      w = mem[g][(base + i) % HD_DEPTH];
      if (w[31:26] == 6'b111111) begin
        n = i + 1;
        ovf = 1'b0;
        break;
      end
    end
  endtask

  // Word i is issued at T+1+i*P and written at T+1+(i+1)*P, P = latency+1.
  task automatic check_model(input int g);
    int p, r, j, d, ehd, ewd;
    bit ew, ed, eov;
    p = lat_of(g) + 1;
    ew = 1'b0; ed = 1'b0; eov = 1'b0; ehd = 0; ewd = 0;
    e_busy[g] = 1'b0;
    if (ld_on[g]) begin
      r = cyc - ld_t[g] - 1;
      d = ld_n[g] * p;
      j = r / p;
      e_busy[g] = (r <= d);
      ed = (r == d);
      ew = (r % p == 0) && (j >= 1) && (j <= ld_n[g]);
      if (ew) begin
        h_addr[g] = j - 1;
        h_pid[g]  = ld_pid[g];
        h_data[g] = mem[g][(ld_base[g] + j - 1) % HD_DEPTH];
      end
      ehd = (ld_base[g] + ((j < ld_n[g]) ? j : ld_n[g] - 1)) % HD_DEPTH;
      if (r >= d) begin
        ewd = ld_n[g];
        eov = ld_ovf[g];
      end
    end
    cmp("m_busy", g, o_busy[g], e_busy[g]);
    cmp("m_done", g, o_done[g], ed);
    cmp("m_we", g, o_we[g], ew);
    cmp("m_page_addr", g, o_addr[g], h_addr[g]);
    cmp("m_page_pid", g, o_pid[g], h_pid[g]);
    cmp("m_page_data", g, o_data[g], h_data[g]);
    cmp("m_hd_addr", g, o_hd[g], ehd);
    cmp("m_words", g, o_words[g], ewd);
    cmp("m_overflow", g, o_ovf[g], eov);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        if (mvalid[g]) check_model(g);
        if (rst_a[g]) begin
          mvalid[g] = 1'b1;
          ld_on[g]  = 1'b0;
          e_busy[g] = 1'b0;
          h_addr[g] = 0;
          h_pid[g]  = 0;
          h_data[g] = '0;
        end else if (mvalid[g] && st[g] && !e_busy[g]) begin
          ld_on[g]   = 1'b1;
          ld_t[g]    = cyc;
          ld_base[g] = int'(sbase[g]);
          ld_pid[g]  = int'(spid[g]);
          prog_len(g, ld_base[g], ld_n[g], ld_ovf[g]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int c);
    while (cyc < c) step();
  endtask

  task automatic peek(input int c);
    go(c);
    #3;
  endtask

  task automatic start(input int g, input int pid, input int base);
    st[g]    = 1'b1;
    spid[g]  = 5'(pid);
    sbase[g] = 10'(base);
    step();
    st[g] = 1'b0;
  endtask

  initial begin
    int t;
    int hd_tab [4];
    int ov_hd [9];
    for (int g = 0; g < N; g++) begin
      for (int a = 0; a < HD_DEPTH; a++) mem[g][a] = '0;
      st[g] = 1'b0; spid[g] = '0; sbase[g] = '0; rst_a[g] = 1'b1;
    end
    mem[0][10] = 32'h0000_0020; mem[0][11] = 32'h0000_0022; mem[0][12] = 32'hFC00_0000;
    mem[0][1022] = 32'h2001_0005; mem[0][1023] = 32'h2002_0006;
    mem[0][0] = 32'h0000_0020; mem[0][1] = 32'hFC00_0001;
    for (int i = 0; i < 4; i++) mem[0][100 + i] = 32'h0400_0000 + 32'(i);
    mem[0][104] = 32'hFC00_0104;
    for (int i = 0; i < 8; i++) mem[1][i] = 32'h1000_0000 + 32'(i);
    mem[2][0] = 32'hFFFF_FFFF;

    go(3);
    for (int g = 0; g < N; g++) rst_a[g] = 1'b0;
    #3;
    cmp("rst_busy", 0, o_busy[0], 0);
    cmp("rst_we", 0, o_we[0], 0);
    cmp("rst_words", 1, o_words[1], 0);
    cmp("rst_hd", 0, o_hd[0], 0);

    // Basic three-word load ending in halt
    t = 5;
    go(t);
    start(0, 3, 10);
    for (int k = 1; k <= 9; k++) begin
      peek(t + k);
      cmp("basic_we", 0, o_we[0], (k == 3 || k == 5 || k == 7));
      cmp("basic_busy", 0, o_busy[0], (k <= 7));
      cmp("basic_done", 0, o_done[0], (k == 7));
      if (k == 3 || k == 5 || k == 7) begin
        cmp("basic_addr", 0, o_addr[0], (k - 3) / 2);
        cmp("basic_pid", 0, o_pid[0], 3);
      end
      if (k == 5) cmp("basic_data", 0, o_data[0], 32'h0000_0022);
      if (k == 7) begin
        cmp("basic_words", 0, o_words[0], 3);
        cmp("basic_ovf", 0, o_ovf[0], 0);
      end
    end

    // HD index wraps past the top of the disk
    t = 20;
    go(t);
    start(0, 7, 1022);
    hd_tab = '{1022, 1023, 0, 1};
    for (int k = 1; k <= 9; k++) begin
      peek(t + k);
      if (k % 2 == 1 && k <= 7) cmp("wrap_hd", 0, o_hd[0], hd_tab[(k - 1) / 2]);
      if (k % 2 == 1 && k >= 3) begin
        cmp("wrap_we", 0, o_we[0], 1);
        cmp("wrap_addr", 0, o_addr[0], (k - 3) / 2);
      end
      if (k == 9) begin
        cmp("wrap_done", 0, o_done[0], 1);
        cmp("wrap_words", 0, o_words[0], 4);
      end
    end

    // Reset one cycle after the second write of a five-word load
    t = 35;
    go(t);
    start(0, 12, 100);
    peek(t + 5);
    cmp("rmid_we2", 0, o_we[0], 1);
    cmp("rmid_addr2", 0, o_addr[0], 1);
    go(t + 6);
    rst_a[0] = 1'b1;
    step();
    rst_a[0] = 1'b0;
    #3;
    cmp("rmid_busy", 0, o_busy[0], 0);
    cmp("rmid_we", 0, o_we[0], 0);
    cmp("rmid_addr", 0, o_addr[0], 0);
    cmp("rmid_pid", 0, o_pid[0], 0);
    cmp("rmid_data", 0, o_data[0], 0);
    cmp("rmid_hd", 0, o_hd[0], 0);
    for (int k = 8; k <= 14; k++) begin
      peek(t + k);
      cmp("rmid_no_we", 0, o_we[0], 0);
    end
    t = 51;
    go(t);
    start(0, 2, 10);
    peek(t + 1);
    cmp("rmid_restart_busy", 0, o_busy[0], 1);
    peek(t + 7);
    cmp("rmid_restart_done", 0, o_done[0], 1);
    cmp("rmid_restart_words", 0, o_words[0], 3);

    // Full 4-slot page without halt, with ignored Start pulses, then a fresh load
    t = 70;
    go(t);
    start(1, 6, 0);
    ov_hd = '{0, 0, 1, 1, 2, 2, 3, 3, 3};
    for (int k = 1; k <= 11; k++) begin
      go(t + k);
      st[1]    = (k == 2 || k == 4 || k == 9 || k == 10);
      spid[1]  = (k == 10) ? 5'd9 : 5'd30;
      sbase[1] = (k == 10) ? 10'd4 : 10'd5;
      #3;
      if (k <= 9) cmp("ovf_hd", 1, o_hd[1], ov_hd[k - 1]);
      if (k % 2 == 1 && k >= 3 && k <= 9) begin
        cmp("ovf_we", 1, o_we[1], 1);
        cmp("ovf_addr", 1, o_addr[1], (k - 3) / 2);
        cmp("ovf_pid", 1, o_pid[1], 6);
      end
      if (k == 9) begin
        cmp("ovf_done", 1, o_done[1], 1);
        cmp("ovf_words", 1, o_words[1], 4);
        cmp("ovf_flag", 1, o_ovf[1], 1);
      end
      if (k == 10) cmp("ovf_idle", 1, o_busy[1], 0);
      if (k == 11) begin
        cmp("fresh_busy", 1, o_busy[1], 1);
        cmp("fresh_words", 1, o_words[1], 0);
        cmp("fresh_ovf", 1, o_ovf[1], 0);
      end
    end
    peek(t + 13);
    cmp("fresh_pid", 1, o_pid[1], 9);
    peek(t + 19);
    cmp("fresh_done", 1, o_done[1], 1);
    cmp("fresh_words_end", 1, o_words[1], 4);

    // Single halt word with three-cycle HD latency
    t = 100;
    go(t);
    start(2, 1, 0);
    for (int k = 1; k <= 7; k++) begin
      peek(t + k);
      cmp("lat3_we", 2, o_we[2], (k == 5));
      cmp("lat3_done", 2, o_done[2], (k == 5));
      cmp("lat3_busy", 2, o_busy[2], (k <= 5));
      if (k == 5) begin
        cmp("lat3_data", 2, o_data[2], 32'hFFFF_FFFF);
        cmp("lat3_words", 2, o_words[2], 1);
        cmp("lat3_ovf", 2, o_ovf[2], 0);
      end
    end

    go(112);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hd_page_loader.md
Name: hd_page_loader

Overview:
- Parametrised boot/program loader that copies one program image from the simulated HD into a process page of the paging memory.
- On a Start request it reads consecutive HD words from a base index and writes them into page slots 0..N-1 for a given PID.
- It stops at the first halt opcode or when the page is full.
- Busy drives the BIOS instruction mux so the CPU is fed BIOS instructions while a load is in progress.

Parameters:
- DATA_W, 32, width of HD and page words.
- HD_AW, 10, HD word-index width.
- PAGE_AW, 6, page slot-index width; page depth = 2^PAGE_AW.
- PID_W, 5, process ID width.
- RD_LAT, 1, HD synchronous read latency in cycles (legal range 1..4).
- HALT_OP, 6'b111111, opcode in bits [DATA_W-1:DATA_W-6] that terminates a load.

Ports:
- Clock  in  1  system clock; all logic is rising-edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  load request, sampled only when Busy=0.
- StartPID  in  PID_W  target process ID, latched on an accepted Start.
- HDBase  in  HD_AW  first HD word index, latched on an accepted Start.
- HD_addr  out  HD_AW  HD read index.
- HD_data  in  DATA_W  HD read data, valid RD_LAT cycles after HD_addr.
- Page_we  out  1  page write strobe.
- Page_pid  out  PID_W  page write PID.
- Page_addr  out  PAGE_AW  page slot index.
- Page_data  out  DATA_W  page write data.
- Busy  out  1  load in progress (also the BIOS select).
- Done  out  1  one-cycle completion pulse.
- WordsLoaded  out  PAGE_AW+1  number of words written in the last load.
- Overflow  out  1  last load filled the page without meeting HALT_OP.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal index 0. Reset mid-load aborts immediately; no further Page_we is issued.
- FSM states: IDLE, ISSUE, WAIT, FINISH.
  - IDLE: Start=1 at cycle T latches PID and base, clears WordsLoaded and Overflow, sets idx=0, goes to ISSUE. Busy=1 from T+1.
  - ISSUE (1 cycle): HD_addr = (base+idx) mod 2^HD_AW; go to WAIT.
  - WAIT (RD_LAT cycles): HD_addr is held. In the last WAIT cycle HD_data is sampled into the write registers.
- Write timing:
  - Page_we pulses in the following cycle with Page_addr=idx, Page_pid=latched PID, Page_data=sampled word.
  - Word i is written at cycle T+1+(i+1)(RD_LAT+1). Throughput is one word per RD_LAT+1 cycles.
  - The next ISSUE overlaps that write cycle.
- Termination:
  - After sampling, if the opcode field equals HALT_OP, or idx=2^PAGE_AW-1, the FSM goes to FINISH.
  - Otherwise idx increments and the FSM returns to ISSUE.
  - The halt word itself is written.
- FINISH (1 cycle, coincides with the final Page_we):
  - Done=1.
  - WordsLoaded = idx+1.
  - Overflow=1 only if the final word is not HALT_OP and idx=2^PAGE_AW-1.
  - Busy stays 1 in this cycle and is 0 from the next; the FSM returns to IDLE.
- Start handling: Start while Busy=1, including the FINISH cycle, is ignored with no queuing.
- Hold values: WordsLoaded and Overflow hold until the next accepted Start.
- HD address wrap: base+idx wraps modulo 2^HD_AW silently.
- Page_addr never exceeds 2^PAGE_AW-1.
- Output values outside active cycles:
  - Page_we is 0 except on write cycles.
  - HD_addr holds its last value in IDLE.
  - Page_addr, Page_pid and Page_data hold their last values when Page_we=0.
- Start and Reset in the same cycle: Reset wins.

Test Plan:
- Basic load, RD_LAT=1: HD[10..12]={ADD, SUB, HALT}, Start at T=0, PID=3, base=10. Required: Page_we at cycles 3, 5, 7 with Page_addr 0, 1, 2 and Page_pid=3; Done at 7; WordsLoaded=3; Overflow=0; Busy high cycles 1..7.
- Overflow, PAGE_AW=2: 8 HD words with no HALT_OP. Required: exactly 4 writes to slots 0..3; Done with WordsLoaded=4 and Overflow=1; HD index base+4 is never issued.
- Latency sweep RD_LAT=3: single HALT word at base 0. Required: one Page_we at cycle T+5 carrying the HALT word; Done in the same cycle; WordsLoaded=1.
- HD wrap: base=1022 (HD_AW=10), 4-word program ending in HALT. Required: HD_addr sequence 1022, 1023, 0, 1; Page_addr sequence 0..3.
- Start ignored: pulse Start at cycles 2, 4 and at the FINISH cycle of a running load. Required: no restart and no latched PID change; a Start one cycle after Busy falls starts a fresh load with WordsLoaded and Overflow cleared.
- Reset mid-load: assert Reset on the cycle after the second Page_we of a 5-word load. Required: all outputs 0 on the next cycle; no further Page_we; the FSM accepts a new Start afterwards.
